// File: rtl/irq_timebase.sv
// irq_timebase: CPU phase-clock divider plus NCH programmable interrupt timers.
// Generates phi_clk/phi_en from CLOCK_50 and raises irq from sticky per-channel pending flags.
//
// Ports:
//   CLOCK_50     in   1         system clock, rising edge
//   resetSystem  in   1         asynchronous active-low reset
//   hold         in   1         freezes the phase divider (phi_clk low, no phi_en)
//   phi_clk      out  1         CPU clock, 50% duty, period 2*CLK_DIV
//   phi_en       out  1         one-cycle pulse coincident with each phi_clk rise
//   irq_ack_l    in   NCH       per-channel acknowledge, active low, level sampled
//   cfg_we       in   1         configuration write strobe
//   cfg_sel      in   SEL_W     channel addressed by cfg_we (>= NCH is ignored)
//   cfg_period   in   PERIOD_W  new period P (effective period is max(P,2))
//   cfg_oneshot  in   1         1 = one-shot, 0 = periodic
//   cfg_mask     in   1         1 = channel may drive irq
//   pending      out  NCH       sticky per-channel terminal flags
//   irq          out  1         OR of pending & mask
module irq_timebase #(
    parameter int CLK_DIV    = 18,
    parameter int NCH        = 2,
    parameter int PERIOD_W   = 17,
    parameter int IRQ_PERIOD = 104167,
    localparam int SEL_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                CLOCK_50,
    input  logic                resetSystem,
    input  logic                hold,
    output logic                phi_clk,
    output logic                phi_en,
    input  logic [NCH-1:0]      irq_ack_l,
    input  logic                cfg_we,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_oneshot,
    input  logic                cfg_mask,
    output logic [NCH-1:0]      pending,
    output logic                irq
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PERIOD_W-1:0] RST_PERIOD = PERIOD_W'(IRQ_PERIOD);
    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] TWO = PERIOD_W'(2);

    // ---------------- phase divider ----------------
    logic [DIV_W-1:0] div_q;
    logic             div_wrap;

    assign div_wrap = (div_q == DIV_LAST);

    always_ff @(posedge CLOCK_50 or negedge resetSystem) begin
        if (!resetSystem) begin
            div_q   <= '0;
            phi_clk <= 1'b0;
            phi_en  <= 1'b0;
        end else if (hold) begin
            div_q   <= '0;
            phi_clk <= 1'b0;
            phi_en  <= 1'b0;
        end else begin
            // registered so the pulse lands on the same edge as the rise
            phi_en <= div_wrap & ~phi_clk;
            if (div_wrap) begin
                div_q   <= '0;
                phi_clk <= ~phi_clk;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    // ---------------- interrupt timers ----------------
    logic [NCH-1:0] irq_vec;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [PERIOD_W-1:0] period_q;
        logic [PERIOD_W-1:0] cnt_q;
        logic [PERIOD_W-1:0] term;
        logic                oneshot_q;
        logic                mask_q;
        logic                done_q;
        logic                pend_q;
        logic                fire;
        logic                ack;
        logic                wr;

        // periods below 2 behave as 2
        assign term = (period_q < TWO) ? ONE : (period_q - ONE);

        // a fired one-shot parks at terminal; done_q stops it re-firing
        assign fire = (cnt_q == term) & ~(oneshot_q & done_q);
        assign ack  = ~irq_ack_l[i];

        // out-of-range selects match no channel, so they are dropped
        assign wr = cfg_we & (cfg_sel == SEL_W'(i));

        always_ff @(posedge CLOCK_50 or negedge resetSystem) begin
            if (!resetSystem) begin
                period_q  <= RST_PERIOD;
                cnt_q     <= '0;
                oneshot_q <= 1'b0;
                mask_q    <= 1'b1;
                done_q    <= 1'b0;
                pend_q    <= 1'b0;
            end else if (wr) begin
                period_q  <= cfg_period;
                oneshot_q <= cfg_oneshot;
                mask_q    <= cfg_mask;
                cnt_q     <= '0;
                done_q    <= 1'b0;
                pend_q    <= 1'b0;
            end else if (fire) begin
                // terminal beats a same-cycle acknowledge
                pend_q <= 1'b1;
                if (oneshot_q) begin
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= '0;
                end
            end else if (oneshot_q && ack) begin
                cnt_q  <= '0;
                done_q <= 1'b0;
                pend_q <= 1'b0;
            end else begin
                if (ack) begin
                    pend_q <= 1'b0;
                end
                if (!(oneshot_q && done_q)) begin
                    cnt_q <= cnt_q + ONE;
                end
            end
        end

        assign pending[i] = pend_q;
        assign irq_vec[i] = pend_q & mask_q;
    end

    assign irq = |irq_vec;

endmodule

// File: tb/tb_irq_timebase.sv
// tb_irq_timebase: directed scoreboard bench for irq_timebase.
// Stimulus queues expected values keyed by edge number; a monitor compares them.
module tb_irq_timebase;

    localparam int S_P0  = 0;
    localparam int S_P1  = 1;
    localparam int S_IRQ = 2;
    localparam int S_PHI = 3;
    localparam int S_EN  = 4;
    localparam int S_P2  = 5;
    localparam int S_IRQ2 = 6;
    localparam int S_PHI2 = 7;
    localparam int S_EN2  = 8;

    typedef struct {
        int         t;
        int         sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t q[$];

    logic        CLOCK_50 = 1'b0;
    logic        resetSystem;
    logic        hold;
    logic [1:0]  ack_l;
    logic        cfg_we;
    logic [0:0]  cfg_sel;
    logic [16:0] cfg_period;
    logic        cfg_oneshot;
    logic        cfg_mask;
    logic        phi_clk;
    logic        phi_en;
    logic [1:0]  pending;
    logic        irq;

    logic [2:0]  ack2_l;
    logic        cfg_we2;
    logic [1:0]  cfg_sel2;
    logic [16:0] cfg_period2;
    logic        cfg_oneshot2;
    logic        cfg_mask2;
    logic        phi_clk2;
    logic        phi_en2;
    logic [2:0]  pending2;
    logic        irq2;

    int cyc = 0;
    int base = 0;
    int n_vec = 0;
    int n_err = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    irq_timebase #(
        .CLK_DIV(3), .NCH(2), .PERIOD_W(17), .IRQ_PERIOD(10)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .resetSystem(resetSystem),
        .hold       (hold),
        .phi_clk    (phi_clk),
        .phi_en     (phi_en),
        .irq_ack_l  (ack_l),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_period (cfg_period),
        .cfg_oneshot(cfg_oneshot),
        .cfg_mask   (cfg_mask),
        .pending    (pending),
        .irq        (irq)
    );

    irq_timebase #(
        .CLK_DIV(3), .NCH(3), .PERIOD_W(17), .IRQ_PERIOD(10)
    ) dut2 (
        .CLOCK_50   (CLOCK_50),
        .resetSystem(resetSystem),
        .hold       (hold),
        .phi_clk    (phi_clk2),
        .phi_en     (phi_en2),
        .irq_ack_l  (ack2_l),
        .cfg_we     (cfg_we2),
        .cfg_sel    (cfg_sel2),
        .cfg_period (cfg_period2),
        .cfg_oneshot(cfg_oneshot2),
        .cfg_mask   (cfg_mask2),
        .pending    (pending2),
        .irq        (irq2)
    );

    function automatic void push(input int t, input int sig,
                                 input logic [7:0] val, input string name);
        exp_t e;
        int   i;
        e.t    = base + t;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        i = q.size();
        while (i > 0 && q[i-1].t > e.t) i--;
        q.insert(i, e);
    endfunction

    function automatic logic [7:0] sample(input int sig);
        case (sig)
            S_P0:    return {7'b0, pending[0]};
            S_P1:    return {7'b0, pending[1]};
            S_IRQ:   return {7'b0, irq};
            S_PHI:   return {7'b0, phi_clk};
            S_EN:    return {7'b0, phi_en};
            S_P2:    return {5'b0, pending2};
            S_IRQ2:  return {7'b0, irq2};
            S_PHI2:  return {7'b0, phi_clk2};
            S_EN2:   return {7'b0, phi_en2};
            default: return 8'hff;
        endcase
    endfunction

    task automatic wait_to(input int n);
        while (cyc < base + n) @(negedge CLOCK_50);
    endtask

    // monitor: sample just after each falling edge, well away from the rising edge
    initial begin
        exp_t       e;
        logic [7:0] got;
        forever begin
            @(negedge CLOCK_50);
            #1;
            while (q.size() > 0 && q[0].t <= cyc) begin
                e = q.pop_front();
                n_vec++;
                if (e.t < cyc) begin
                    n_err++;
                    $display("FAIL %s: missed edge %0d, now %0d, required %0h",
                             e.name, e.t, cyc, e.val);
                end else begin
                    got = sample(e.sig);
                    if (got !== e.val) begin
                        n_err++;
                        $display("FAIL %s @cyc %0d: got %0h, required %0h",
                                 e.name, cyc, got, e.val);
                    end
                end
            end
        end
    end

    initial begin
        resetSystem  = 1'b0;
        hold         = 1'b0;
        ack_l        = 2'b11;
        cfg_we       = 1'b0;
        cfg_sel      = 1'b0;
        cfg_period   = '0;
        cfg_oneshot  = 1'b0;
        cfg_mask     = 1'b1;
        ack2_l       = 3'b111;
        cfg_we2      = 1'b0;
        cfg_sel2     = 2'd0;
        cfg_period2  = '0;
        cfg_oneshot2 = 1'b0;
        cfg_mask2    = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        // ---- A: reset release, default period 10 ----
        resetSystem = 1'b1;
        base = cyc;
        push(0,  S_P0,  8'd0, "A_rst_p0");
        push(0,  S_P1,  8'd0, "A_rst_p1");
        push(0,  S_IRQ, 8'd0, "A_rst_irq");
        push(0,  S_PHI, 8'd0, "A_rst_phi");
        push(0,  S_EN,  8'd0, "A_rst_en");
        push(0,  S_P2,  8'd0, "A_rst_p2");
        push(2,  S_PHI, 8'd0, "A_phi_e2");
        push(3,  S_PHI, 8'd1, "A_phi_e3");
        push(3,  S_EN,  8'd1, "A_en_e3");
        push(3,  S_PHI2, 8'd1, "A_phi2_e3");
        push(3,  S_EN2, 8'd1, "A_en2_e3");
        push(3,  S_P2,  8'd0, "A_oor_p2_e3");
        push(4,  S_EN,  8'd0, "A_en_e4");
        push(5,  S_PHI, 8'd1, "A_phi_e5");
        push(6,  S_PHI, 8'd0, "A_phi_e6");
        push(8,  S_EN,  8'd0, "A_en_e8");
        push(9,  S_PHI, 8'd1, "A_phi_e9");
        push(9,  S_EN,  8'd1, "A_en_e9");
        push(9,  S_P0,  8'd0, "A_p0_e9");
        push(9,  S_P1,  8'd0, "A_p1_e9");
        push(9,  S_IRQ, 8'd0, "A_irq_e9");
        push(9,  S_P2,  8'd0, "A_oor_p2_e9");
        push(10, S_P0,  8'd1, "A_p0_e10");
        push(10, S_P1,  8'd1, "A_p1_e10");
        push(10, S_IRQ, 8'd1, "A_irq_e10");
        push(10, S_P2,  8'd7, "A_oor_p2_e10");
        push(10, S_IRQ2, 8'd1, "A_oor_irq2_e10");
        // ---- B: periodic acknowledge ----
        push(11, S_P0,  8'd1, "B_p0_e11");
        push(12, S_P0,  8'd0, "B_ack_p0_e12");
        push(12, S_P1,  8'd1, "B_p1_e12");
        push(12, S_IRQ, 8'd1, "B_irq_e12");
        push(19, S_P0,  8'd0, "B_p0_e19");
        push(20, S_P0,  8'd1, "B_tie_p0_e20");
        push(21, S_P0,  8'd1, "B_tie_p0_e21");

        // out-of-range write on the 3-channel instance
        cfg_we2      = 1'b1;
        cfg_sel2     = 2'd3;
        cfg_period2  = 17'd2;
        cfg_oneshot2 = 1'b1;
        cfg_mask2    = 1'b0;
        wait_to(1);
        cfg_we2 = 1'b0;
        wait_to(11);
        ack_l = 2'b10;
        wait_to(12);
        ack_l = 2'b11;
        wait_to(19);
        ack_l = 2'b10;
        wait_to(20);
        ack_l = 2'b11;
        wait_to(22);

        // ---- C: one-shot on ch1, P=5 ----
        base = cyc + 1;
        cfg_we      = 1'b1;
        cfg_sel     = 1'b1;
        cfg_period  = 17'd5;
        cfg_oneshot = 1'b1;
        cfg_mask    = 1'b1;
        push(0,  S_P1, 8'd0, "C_cfg_p1_e0");
        push(4,  S_P1, 8'd0, "C_p1_e4");
        push(5,  S_P1, 8'd1, "C_p1_e5");
        push(7,  S_P1, 8'd1, "C_hold_p1_e7");
        push(8,  S_P1, 8'd0, "C_ack_p1_e8");
        push(12, S_P1, 8'd0, "C_p1_e12");
        push(13, S_P1, 8'd1, "C_p1_e13");
        wait_to(0);
        cfg_we = 1'b0;
        wait_to(7);
        ack_l = 2'b01;
        wait_to(8);
        ack_l = 2'b11;
        wait_to(14);

        // ---- D: ch0 masked with P=0, both acks held low ----
        base = cyc + 1;
        ack_l       = 2'b00;
        cfg_we      = 1'b1;
        cfg_sel     = 1'b0;
        cfg_period  = 17'd0;
        cfg_oneshot = 1'b0;
        cfg_mask    = 1'b0;
        push(0,  S_P0,  8'd0, "D_p0_e0");
        push(0,  S_P1,  8'd0, "D_p1_e0");
        push(1,  S_P0,  8'd0, "D_p0_e1");
        push(2,  S_P0,  8'd1, "D_p0_e2");
        push(3,  S_P0,  8'd0, "D_p0_e3");
        push(4,  S_P0,  8'd1, "D_p0_e4");
        push(5,  S_P0,  8'd0, "D_p0_e5");
        for (int k = 0; k <= 5; k++) push(k, S_IRQ, 8'd0, "D_mask_irq");
        push(6,  S_P0,  8'd1, "D_p0_e6");
        push(9,  S_P1,  8'd0, "D_p1_e9");
        push(9,  S_IRQ, 8'd0, "D_irq_e9");
        push(10, S_P1,  8'd1, "D_p1_e10");
        push(10, S_IRQ, 8'd1, "D_irq_e10");
        wait_to(0);
        cfg_we = 1'b0;
        wait_to(5);
        ack_l = 2'b11;
        wait_to(11);

        // ---- E: ch0 P=7, then hold for 10 edges ----
        base = cyc + 1;
        cfg_we      = 1'b1;
        cfg_sel     = 1'b0;
        cfg_period  = 17'd7;
        cfg_oneshot = 1'b0;
        cfg_mask    = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            push(k, S_PHI, 8'd0, "E_hold_phi");
            push(k, S_EN,  8'd0, "E_hold_en");
        end
        push(6,  S_P0,  8'd0, "E_p0_e6");
        push(7,  S_P0,  8'd1, "E_p0_e7");
        push(7,  S_IRQ, 8'd1, "E_irq_e7");
        push(12, S_PHI, 8'd0, "E_phi_e12");
        push(13, S_PHI, 8'd1, "E_phi_e13");
        push(13, S_EN,  8'd1, "E_en_e13");
        wait_to(0);
        cfg_we = 1'b0;
        hold   = 1'b1;
        wait_to(10);
        hold = 1'b0;
        wait_to(14);

        // ---- F: asynchronous reset mid-run ----
        push(14, S_P0,  8'd0, "F_async_p0");
        push(14, S_P1,  8'd0, "F_async_p1");
        push(14, S_IRQ, 8'd0, "F_async_irq");
        push(14, S_PHI, 8'd0, "F_async_phi");
        push(14, S_EN,  8'd0, "F_async_en");
        resetSystem = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        resetSystem = 1'b1;
        base = cyc;
        push(3,  S_PHI, 8'd1, "F_phi_e3");
        push(3,  S_EN,  8'd1, "F_en_e3");
        push(9,  S_P0,  8'd0, "F_p0_e9");
        push(9,  S_P1,  8'd0, "F_p1_e9");
        push(10, S_P0,  8'd1, "F_p0_e10");
        push(10, S_P1,  8'd1, "F_p1_e10");
        push(10, S_IRQ, 8'd1, "F_irq_e10");
        wait_to(11);

        for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge CLOCK_50);
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        @(negedge CLOCK_50);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
